alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 202 ++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers (MIPS style).
// Optional macro ALU_MULDIV_DIV_EN adds the restoring divider; otherwise DIV/DIVU are illegal.
module alu_muldiv #(
    parameter int BITS_SIZE = 32,
    parameter int BITS_OP   = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [BITS_OP-1:0]   i_op,
    input  logic [BITS_SIZE-1:0] i_data_a,
    input  logic [BITS_SIZE-1:0] i_data_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [BITS_SIZE-1:0] o_hi,
    output logic [BITS_SIZE-1:0] o_lo,
    output logic                 o_div_zero
);

    localparam int N  = BITS_SIZE;
    localparam int CW = $clog2(BITS_SIZE) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    localparam logic [BITS_OP-1:0] OP_MULT  = BITS_OP'(0);
    localparam logic [BITS_OP-1:0] OP_MULTU = BITS_OP'(1);
    localparam logic [BITS_OP-1:0] OP_MTHI  = BITS_OP'(4);
    localparam logic [BITS_OP-1:0] OP_MTLO  = BITS_OP'(5);
`ifdef ALU_MULDIV_DIV_EN
    localparam logic [BITS_OP-1:0] OP_DIV   = BITS_OP'(2);
    localparam logic [BITS_OP-1:0] OP_DIVU  = BITS_OP'(3);
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX} state_t;

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic [N-1:0]    r_hi;
    logic [N-1:0]    r_lo;
    logic [CW-1:0]   r_cnt;
    logic [N:0]      r_rem;
    logic [N-1:0]    r_quo;
    logic [N-1:0]    r_mcand;
    logic            r_negRes;

    logic            w_isMul;
    logic            w_isDiv;
    logic            w_signedOp;
    logic            w_negA;
    logic            w_negB;
    logic [N-1:0]    w_magA;
    logic [N-1:0]    w_magB;
    logic [N:0]      w_mulSum;
    logic [2*N-1:0]  w_prod;
    logic [2*N-1:0]  w_prodFix;

    assign w_isMul = (i_op == OP_MULT) || (i_op == OP_MULTU);
`ifdef ALU_MULDIV_DIV_EN
    assign w_isDiv    = (i_op == OP_DIV) || (i_op == OP_DIVU);
    assign w_signedOp = (i_op == OP_MULT) || (i_op == OP_DIV);
`else
    assign w_isDiv    = 1'b0;
    assign w_signedOp = (i_op == OP_MULT);
`endif

    // Iteration always runs on magnitudes; signs are restored in FIX.
    assign w_negA = w_signedOp & i_data_a[N-1];
    assign w_negB = w_signedOp & i_data_b[N-1];
    assign w_magA = w_negA ? (-i_data_a) : i_data_a;
    assign w_magB = w_negB ? (-i_data_b) : i_data_b;

    assign w_mulSum  = r_rem + ({1'b0, r_mcand} & {(N+1){r_quo[0]}});
    assign w_prod    = {r_rem[N-1:0], r_quo};
    assign w_prodFix = r_negRes ? (-w_prod) : w_prod;

`ifdef ALU_MULDIV_DIV_EN
    logic            r_isDiv;
    logic            r_negRem;
    logic            r_bZero;
    logic            r_divZero;
    logic [N-1:0]    r_a;
    logic [N:0]      w_divShift;
    logic [N:0]      w_divDiff;
    logic            w_divNeg;
    logic [N-1:0]    w_quoFix;
    logic [N-1:0]    w_remFix;

    assign w_divShift = {r_rem[N-1:0], r_quo[N-1]};
    assign w_divDiff  = w_divShift - {1'b0, r_mcand};
    assign w_divNeg   = w_divDiff[N];
    assign w_quoFix   = r_negRes ? (-r_quo) : r_quo;
    assign w_remFix   = r_negRem ? (-r_rem[N-1:0]) : r_rem[N-1:0];
    assign o_div_zero = r_divZero;
`else
    assign o_div_zero = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_mcand  <= '0;
            r_negRes <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
            r_isDiv   <= 1'b0;
            r_negRem  <= 1'b0;
            r_bZero   <= 1'b0;
            r_divZero <= 1'b0;
            r_a       <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
`ifdef ALU_MULDIV_DIV_EN
                        r_divZero <= 1'b0;
`endif
                        if (w_isMul || w_isDiv) begin
                            r_state  <= ST_CALC;
                            r_busy   <= 1'b1;
                            r_cnt    <= '0;
                            r_rem    <= '0;
                            r_negRes <= w_negA ^ w_negB;
                            // Multiply shifts the multiplier out of r_quo; divide shifts the dividend.
                            r_quo    <= w_isMul ? w_magB : w_magA;
                            r_mcand  <= w_isMul ? w_magA : w_magB;
`ifdef ALU_MULDIV_DIV_EN
                            r_isDiv  <= w_isDiv;
                            r_negRem <= w_negA;
                            r_bZero  <= (i_data_b == '0);
                            r_a      <= i_data_a;
`endif
                        end else if (i_op == OP_MTHI) begin
                            r_hi   <= i_data_a;
                            r_done <= 1'b1;
                        end else if (i_op == OP_MTLO) begin
                            r_lo   <= i_data_a;
                            r_done <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        r_state <= ST_FIX;
                    end
`ifdef ALU_MULDIV_DIV_EN
                    if (r_isDiv) begin
                        r_rem <= w_divNeg ? w_divShift : w_divDiff;
                        r_quo <= {r_quo[N-2:0], ~w_divNeg};
                    end else
`endif
                    begin
                        r_rem <= {1'b0, w_mulSum[N:1]};
                        r_quo <= {w_mulSum[0], r_quo[N-1:1]};
                    end
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_cnt   <= '0;
`ifdef ALU_MULDIV_DIV_EN
                    if (r_isDiv) begin
                        if (r_bZero) begin
                            r_hi      <= r_a;
                            r_lo      <= '1;
                            r_divZero <= 1'b1;
                        end else begin
                            r_hi <= w_remFix;
                            r_lo <= w_quoFix;
                        end
                    end else
`endif
                    begin
                        r_hi <= w_prodFix[2*N-1:N];
                        r_lo <= w_prodFix[N-1:0];
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (BITS_SIZE=32); covers the divider
// only when ALU_MULDIV_DIV_EN is defined, otherwise checks DIV/DIVU are treated as illegal.
module tb_alu_muldiv;

    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic [2:0]  i_op;
    logic [31:0] i_data_a;
    logic [31:0] i_data_b;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_div_zero;

    int checks = 0;
    int errors = 0;
    int edges;
    int busyCnt;
    int doneCnt;

    alu_muldiv #(.BITS_SIZE(32), .BITS_OP(3)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_data_a   (i_data_a),
        .i_data_b   (i_data_b),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_hi       (o_hi),
        .o_lo       (o_lo),
        .o_div_zero (o_div_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Issues one request, scrambles the inputs after acceptance, and waits (bounded) for o_done.
    // edgesOut = number of edges after the accept edge at which o_done is visible (-1 on timeout).
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output int edgesOut, output int busyOut);
        @(negedge i_clk);
        i_start  = 1'b1;
        i_op     = op;
        i_data_a = a;
        i_data_b = b;
        @(posedge i_clk);
        #1;
        i_start  = 1'b0;
        i_op     = 3'b110;
        i_data_a = $urandom;
        i_data_b = $urandom;
        edgesOut = -1;
        busyOut  = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge i_clk);
            if (o_busy) busyOut++;
            if (o_done) begin
                edgesOut = n - 1;
                break;
            end
        end
    endtask

    initial begin
        i_reset  = 1'b1;
        i_start  = 1'b0;
        i_op     = 3'b000;
        i_data_a = '0;
        i_data_b = '0;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_hi", o_hi, 0);
        checkOutput("rst_lo", o_lo, 0);
        checkOutput("rst_divz", o_div_zero, 0);

        applyStimulus(3'b000, 32'hFFFFFFFD, 32'd5, edges, busyCnt);
        checkOutput("mult_neg_lat", edges, 33);
        checkOutput("mult_neg_busy", busyCnt, 33);
        checkOutput("mult_neg_hi", o_hi, 32'hFFFFFFFF);
        checkOutput("mult_neg_lo", o_lo, 32'hFFFFFFF1);
        @(negedge i_clk);
        checkOutput("mult_neg_pulse", o_done, 0);

        applyStimulus(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, edges, busyCnt);
        checkOutput("multu_max_busy", busyCnt, 33);
        checkOutput("multu_max_hi", o_hi, 32'hFFFFFFFE);
        checkOutput("multu_max_lo", o_lo, 32'h00000001);

        applyStimulus(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, edges, busyCnt);
        checkOutput("mult_m1m1_hi", o_hi, 32'h00000000);
        checkOutput("mult_m1m1_lo", o_lo, 32'h00000001);

        applyStimulus(3'b000, 32'h80000000, 32'h80000000, edges, busyCnt);
        checkOutput("mult_minmin_hi", o_hi, 32'h40000000);
        checkOutput("mult_minmin_lo", o_lo, 32'h00000000);

        applyStimulus(3'b001, 32'h00001234, 32'h00005678, edges, busyCnt);
        checkOutput("multu_small_hi", o_hi, 32'h00000000);
        checkOutput("multu_small_lo", o_lo, 32'h06260060);

        applyStimulus(3'b100, 32'h00001234, 32'h0, edges, busyCnt);
        checkOutput("mthi_lat", edges, 0);
        checkOutput("mthi_busy", busyCnt, 0);
        checkOutput("mthi_hi", o_hi, 32'h00001234);
        checkOutput("mthi_lo", o_lo, 32'h06260060);

        applyStimulus(3'b101, 32'hCAFEBABE, 32'h0, edges, busyCnt);
        checkOutput("mtlo_lat", edges, 0);
        checkOutput("mtlo_lo", o_lo, 32'hCAFEBABE);

        applyStimulus(3'b111, 32'h11111111, 32'h22222222, edges, busyCnt);
        checkOutput("ill7_lat", edges, 0);
        checkOutput("ill7_busy", busyCnt, 0);
        checkOutput("ill7_hi", o_hi, 32'h00001234);
        checkOutput("ill7_lo", o_lo, 32'hCAFEBABE);

`ifdef ALU_MULDIV_DIV_EN
        applyStimulus(3'b010, 32'hFFFFFFF9, 32'd2, edges, busyCnt);
        checkOutput("div_m7_lat", edges, 33);
        checkOutput("div_m7_lo", o_lo, 32'hFFFFFFFD);
        checkOutput("div_m7_hi", o_hi, 32'hFFFFFFFF);

        applyStimulus(3'b010, 32'h80000000, 32'hFFFFFFFF, edges, busyCnt);
        checkOutput("div_ovf_lo", o_lo, 32'h80000000);
        checkOutput("div_ovf_hi", o_hi, 32'h00000000);
        checkOutput("div_ovf_divz", o_div_zero, 0);

        applyStimulus(3'b010, 32'd7, 32'hFFFFFFFE, edges, busyCnt);
        checkOutput("div_7m2_lo", o_lo, 32'hFFFFFFFD);
        checkOutput("div_7m2_hi", o_hi, 32'h00000001);

        applyStimulus(3'b011, 32'd100, 32'd7, edges, busyCnt);
        checkOutput("divu_100_lo", o_lo, 32'd14);
        checkOutput("divu_100_hi", o_hi, 32'd2);

        applyStimulus(3'b011, 32'hFFFFFFFF, 32'd1, edges, busyCnt);
        checkOutput("divu_max_lo", o_lo, 32'hFFFFFFFF);
        checkOutput("divu_max_hi", o_hi, 32'h00000000);

        applyStimulus(3'b011, 32'd10, 32'd0, edges, busyCnt);
        checkOutput("divu_z_lat", edges, 33);
        checkOutput("divu_z_hi", o_hi, 32'h0000000A);
        checkOutput("divu_z_lo", o_lo, 32'hFFFFFFFF);
        checkOutput("divu_z_divz", o_div_zero, 1);

        applyStimulus(3'b000, 32'd2, 32'd3, edges, busyCnt);
        checkOutput("mult_clr_divz", o_div_zero, 0);
        checkOutput("mult_clr_lo", o_lo, 32'd6);

        applyStimulus(3'b010, 32'hFFFFFFF0, 32'd0, edges, busyCnt);
        checkOutput("div_z_hi", o_hi, 32'hFFFFFFF0);
        checkOutput("div_z_lo", o_lo, 32'hFFFFFFFF);
        checkOutput("div_z_divz", o_div_zero, 1);
`else
        applyStimulus(3'b010, 32'd5, 32'd0, edges, busyCnt);
        checkOutput("nodiv_div_lat", edges, 0);
        checkOutput("nodiv_div_busy", busyCnt, 0);
        checkOutput("nodiv_div_hi", o_hi, 32'h00001234);
        checkOutput("nodiv_div_lo", o_lo, 32'hCAFEBABE);
        checkOutput("nodiv_div_divz", o_div_zero, 0);

        applyStimulus(3'b011, 32'd9, 32'd3, edges, busyCnt);
        checkOutput("nodiv_divu_lat", edges, 0);
        checkOutput("nodiv_divu_busy", busyCnt, 0);
        checkOutput("nodiv_divu_lo", o_lo, 32'hCAFEBABE);
`endif

        // Second request held high through the o_done cycle of the first one.
        @(negedge i_clk);
        i_start  = 1'b1;
        i_op     = 3'b100;
        i_data_a = 32'h0000ABCD;
        @(posedge i_clk);
        #1;
        i_op     = 3'b101;
        i_data_a = 32'h00005A5A;
        @(negedge i_clk);
        checkOutput("b2b_done1", o_done, 1);
        checkOutput("b2b_hi", o_hi, 32'h0000ABCD);
        @(posedge i_clk);
        #1 i_start = 1'b0;
        @(negedge i_clk);
        checkOutput("b2b_done2", o_done, 1);
        checkOutput("b2b_lo", o_lo, 32'h00005A5A);

        // MULTU interrupted: ignored start at step 5, reset at step 10.
        @(negedge i_clk);
        i_start  = 1'b1;
        i_op     = 3'b001;
        i_data_a = 32'd3;
        i_data_b = 32'd5;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        i_start  = 1'b1;
        i_op     = 3'b101;
        i_data_a = 32'h0000DEAD;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        @(negedge i_clk);
        checkOutput("ign_busy", o_busy, 1);
        checkOutput("ign_done", o_done, 0);
        checkOutput("ign_lo", o_lo, 32'h00005A5A);
        repeat (4) @(posedge i_clk);
        #1 i_reset = 1'b1;
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        checkOutput("abort_busy", o_busy, 0);
        checkOutput("abort_done", o_done, 0);
        checkOutput("abort_hi", o_hi, 0);
        checkOutput("abort_lo", o_lo, 0);
        checkOutput("abort_divz", o_div_zero, 0);
        doneCnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge i_clk);
            if (o_done) doneCnt++;
        end
        checkOutput("abort_no_done", doneCnt, 0);

        applyStimulus(3'b001, 32'h00010000, 32'h00010000, edges, busyCnt);
        checkOutput("post_rst_lat", edges, 33);
        checkOutput("post_rst_hi", o_hi, 32'h00000001);
        checkOutput("post_rst_lo", o_lo, 32'h00000000);

        // Reset and start on the same edge: reset must win.
        @(negedge i_clk);
        i_reset  = 1'b1;
        i_start  = 1'b1;
        i_op     = 3'b100;
        i_data_a = 32'h00000055;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        i_start = 1'b0;
        @(negedge i_clk);
        checkOutput("prio_hi", o_hi, 0);
        checkOutput("prio_done", o_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
